// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: sequences one package from the issue/RF mult slot through the multi-cycle
// multiplier. It starts the multiplier, counts its latency, requests the shared writeback
// port, and pulses mult_done to reload the slot.
// Optional feature macro: MULT_PERF_CNT_EN (retirement and writeback-stall counters).
module mult_issue_ctrl #(
    parameter int unsigned PKG_W    = 66,
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PKG_W-1:0] mult_inst_pkg_in,
    input  logic             flush,
    input  logic             wb_grant,
    output logic             mult_start,
    output logic             mult_cancel,
    output logic [PKG_W-1:0] mult_pkg_out,
    output logic             wb_req,
    output logic             busy,
    output logic             mult_done,
    output logic [15:0]      perf_ops,
    output logic [15:0]      perf_wb_stall
);

    typedef enum logic [1:0] {StIdle, StBusy, StWaitWb} state_e;

    // Counter value loaded on accept; it is still at this value only in the first BUSY cycle.
    localparam logic [CNT_W-1:0] LatInit = CNT_W'(MULT_LAT - 1);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [PKG_W-1:0] r_pkg, w_pkg_nxt;

    // State, latency counter and held package registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_pkg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pkg   <= w_pkg_nxt;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pkg_nxt   = r_pkg;
        mult_start  = 1'b0;
        mult_cancel = 1'b0;
        wb_req      = 1'b0;
        case (r_state)
            StIdle: begin
                if (mult_inst_pkg_in[PKG_W-1] && !flush) begin
                    w_state_nxt = StBusy;
                    w_cnt_nxt   = LatInit;
                    w_pkg_nxt   = mult_inst_pkg_in;
                end
            end
            StBusy: begin
                mult_start = (r_cnt == LatInit);
                if (flush) begin
                    w_state_nxt          = StIdle;
                    w_pkg_nxt[PKG_W-1]   = 1'b0;
                    mult_cancel          = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = StWaitWb;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            StWaitWb: begin
                // Still asserted under flush; the arbiter ignores it in that cycle
                wb_req = 1'b1;
                if (flush || wb_grant) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign mult_pkg_out = r_pkg;
    assign busy         = (r_state != StIdle);
    // Flush reloads the slot even while idle
    assign mult_done    = flush | ((r_state == StWaitWb) & wb_grant);

`ifdef MULT_PERF_CNT_EN
    logic        w_retire;
    logic        w_stall;
    logic [15:0] r_perf_ops;
    logic [15:0] r_perf_wb_stall;

    assign w_retire = (r_state == StWaitWb) & wb_grant & ~flush;
    assign w_stall  = (r_state == StWaitWb) & ~wb_grant;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_ops      <= '0;
            r_perf_wb_stall <= '0;
        end else begin
            if (w_retire && (r_perf_ops != 16'hFFFF)) begin
                r_perf_ops <= r_perf_ops + 16'd1;
            end
            if (w_stall && (r_perf_wb_stall != 16'hFFFF)) begin
                r_perf_wb_stall <= r_perf_wb_stall + 16'd1;
            end
        end
    end

    assign perf_ops      = r_perf_ops;
    assign perf_wb_stall = r_perf_wb_stall;
`else
    assign perf_ops      = 16'h0000;
    assign perf_wb_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed self-checking bench for mult_issue_ctrl (MULT_LAT=4, PKG_W=66).
module tb_mult_issue_ctrl;

  localparam int unsigned PkgW = 66;

  logic            clk;
  logic            rst_n;
  logic [PkgW-1:0] pkg_in;
  logic            flush;
  logic            wb_grant;
  logic            mult_start;
  logic            mult_cancel;
  logic [PkgW-1:0] mult_pkg_out;
  logic            wb_req;
  logic            busy;
  logic            mult_done;
  logic [15:0]     perf_ops;
  logic [15:0]     perf_wb_stall;

  int n_asrt;
  int n_fail;

  logic [PkgW-1:0] p1, p2, p3, p3_inv, p4, p5, p6;
  logic [15:0]     exp_ops, exp_stall;

  mult_issue_ctrl #(
    .PKG_W   (66),
    .MULT_LAT(4),
    .CNT_W   (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mult_inst_pkg_in(pkg_in),
    .flush           (flush),
    .wb_grant        (wb_grant),
    .mult_start      (mult_start),
    .mult_cancel     (mult_cancel),
    .mult_pkg_out    (mult_pkg_out),
    .wb_req          (wb_req),
    .busy            (busy),
    .mult_done       (mult_done),
    .perf_ops        (perf_ops),
    .perf_wb_stall   (perf_wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fail(input string tag);
    n_fail++;
    $error("FAIL %s", tag);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply this cycle's inputs and let combinational outputs settle
  task automatic drive(input logic [PkgW-1:0] p, input logic f, input logic g);
    pkg_in   = p;
    flush    = f;
    wb_grant = g;
    #1;
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    p1 = 66'h2_0000_0000_0000_1234;
    p2 = 66'h2_0000_0000_0000_5678;
    p3 = 66'h2_0000_0000_0000_9ABC;
    p3_inv = 66'h0_0000_0000_0000_9ABC;
    p4 = 66'h2_0000_0000_0000_DEF0;
    p5 = 66'h3_FFFF_0000_1111_0001;
    p6 = 66'h2_8000_0000_2222_0002;
    exp_ops   = 16'd0;
    exp_stall = 16'd0;

    // Reset with a valid package present
    rst_n = 1'b0;
    drive(p1, 1'b0, 1'b1);
    tick();
    tick();
    n_asrt++; if (busy !== 1'b0) fail("rst_busy");
    n_asrt++; if (mult_start !== 1'b0) fail("rst_start");
    n_asrt++; if (mult_pkg_out !== 66'h0) fail("rst_pkg");
    n_asrt++; if (wb_req !== 1'b0) fail("rst_wbreq");
    n_asrt++; if (mult_done !== 1'b0) fail("rst_done");
    n_asrt++; if (perf_ops !== 16'h0) fail("rst_perf_ops");
    n_asrt++; if (perf_wb_stall !== 16'h0) fail("rst_perf_stall");

    // Single op, grant held high
    rst_n = 1'b1;
    drive(p1, 1'b0, 1'b1);            // cycle 0
    n_asrt++; if (mult_start !== 1'b0) fail("s_c0_start");
    tick(); drive(p1, 1'b0, 1'b1);    // cycle 1
    n_asrt++; if (mult_start !== 1'b1) fail("s_c1_start");
    n_asrt++; if (busy !== 1'b1) fail("s_c1_busy");
    n_asrt++; if (mult_pkg_out !== p1) fail("s_c1_pkg");
    tick(); drive(p1, 1'b0, 1'b1);    // cycle 2
    n_asrt++; if (mult_start !== 1'b0) fail("s_c2_start");
    tick(); drive(p1, 1'b0, 1'b1);    // cycle 3
    tick(); drive(p1, 1'b0, 1'b1);    // cycle 4
    n_asrt++; if (wb_req !== 1'b0) fail("s_c4_wbreq");
    n_asrt++; if (mult_done !== 1'b0) fail("s_c4_done");
    tick(); drive(p1, 1'b0, 1'b1);    // cycle 5
    n_asrt++; if (wb_req !== 1'b1) fail("s_c5_wbreq");
    n_asrt++; if (mult_done !== 1'b1) fail("s_c5_done");
    tick(); drive('0, 1'b0, 1'b1);    // cycle 6, slot reloaded empty
    n_asrt++; if (busy !== 1'b0) fail("s_c6_busy");
    n_asrt++; if (mult_done !== 1'b0) fail("s_c6_done");
`ifdef MULT_PERF_CNT_EN
    exp_ops = 16'd1;
`endif
    n_asrt++; if (perf_ops !== exp_ops) fail("s_perf_ops");

    // Writeback stall: three ungranted WAIT_WB cycles
    drive(p2, 1'b0, 1'b0);            // cycle 0
    tick(); drive(p2, 1'b0, 1'b0);    // cycle 1
    n_asrt++; if (mult_start !== 1'b1) fail("w_c1_start");
    for (int i = 2; i <= 4; i++) begin
      tick(); drive(p2, 1'b0, 1'b0);
    end
    for (int i = 5; i <= 7; i++) begin
      tick(); drive(p2, 1'b0, 1'b0);
      n_asrt++; if (wb_req !== 1'b1) fail("w_stall_wbreq");
      n_asrt++; if (mult_done !== 1'b0) fail("w_stall_done");
    end
    tick(); drive(p2, 1'b0, 1'b1);    // cycle 8, grant
    n_asrt++; if (wb_req !== 1'b1) fail("w_c8_wbreq");
    n_asrt++; if (mult_done !== 1'b1) fail("w_c8_done");
    tick(); drive('0, 1'b0, 1'b0);    // cycle 9
    n_asrt++; if (busy !== 1'b0) fail("w_c9_busy");
    n_asrt++; if (wb_req !== 1'b0) fail("w_c9_wbreq");
`ifdef MULT_PERF_CNT_EN
    exp_ops   = 16'd2;
    exp_stall = 16'd3;
`endif
    n_asrt++; if (perf_ops !== exp_ops) fail("w_perf_ops");
    n_asrt++; if (perf_wb_stall !== exp_stall) fail("w_perf_stall");

    // Flush in BUSY two cycles after mult_start
    drive(p3, 1'b0, 1'b1);            // cycle 0
    tick(); drive(p3, 1'b0, 1'b1);    // cycle 1
    n_asrt++; if (mult_start !== 1'b1) fail("f_c1_start");
    tick(); drive(p3, 1'b0, 1'b1);    // cycle 2
    n_asrt++; if (mult_cancel !== 1'b0) fail("f_c2_cancel");
    tick(); drive(p3, 1'b1, 1'b1);    // cycle 3, flush
    n_asrt++; if (mult_cancel !== 1'b1) fail("f_c3_cancel");
    n_asrt++; if (mult_done !== 1'b1) fail("f_c3_done");
    n_asrt++; if (wb_req !== 1'b0) fail("f_c3_wbreq");
    tick(); drive('0, 1'b0, 1'b1);    // cycle 4
    n_asrt++; if (busy !== 1'b0) fail("f_c4_busy");
    n_asrt++; if (mult_pkg_out !== p3_inv) fail("f_c4_pkg");
    n_asrt++; if (mult_cancel !== 1'b0) fail("f_c4_cancel");
    for (int i = 0; i < 4; i++) begin
      tick(); drive('0, 1'b0, 1'b1);
      n_asrt++; if (wb_req !== 1'b0) fail("f_no_wbreq");
    end

    // Flush while idle with a valid package: slot reloads, op not accepted
    drive(p4, 1'b1, 1'b0);
    n_asrt++; if (mult_done !== 1'b1) fail("fi_done");
    n_asrt++; if (mult_cancel !== 1'b0) fail("fi_cancel");
    tick(); drive('0, 1'b0, 1'b0);
    n_asrt++; if (busy !== 1'b0) fail("fi_busy");

    // Flush together with grant in WAIT_WB
    drive(p4, 1'b0, 1'b0);            // cycle 0
    for (int i = 1; i <= 4; i++) begin
      tick(); drive(p4, 1'b0, 1'b0);
    end
    tick(); drive(p4, 1'b1, 1'b1);    // cycle 5, WAIT_WB
    n_asrt++; if (wb_req !== 1'b1) fail("fg_c5_wbreq");
    n_asrt++; if (mult_done !== 1'b1) fail("fg_c5_done");
    n_asrt++; if (mult_cancel !== 1'b0) fail("fg_c5_cancel");
    tick(); drive('0, 1'b0, 1'b0);    // cycle 6
    n_asrt++; if (busy !== 1'b0) fail("fg_c6_busy");
    n_asrt++; if (perf_ops !== exp_ops) fail("fg_perf_ops");
    n_asrt++; if (perf_wb_stall !== exp_stall) fail("fg_perf_stall");

    // Back-to-back: second package loaded on first mult_done
    drive(p5, 1'b0, 1'b1);            // cycle 0
    tick(); drive(p5, 1'b0, 1'b1);    // cycle 1
    n_asrt++; if (mult_start !== 1'b1) fail("b_c1_start");
    n_asrt++; if (mult_pkg_out !== p5) fail("b_c1_pkg");
    for (int i = 2; i <= 4; i++) begin
      tick(); drive(p5, 1'b0, 1'b1);
      n_asrt++; if (mult_start !== 1'b0) fail("b_no_dup_start");
    end
    tick(); drive(p5, 1'b0, 1'b1);    // cycle 5
    n_asrt++; if (mult_done !== 1'b1) fail("b_c5_done");
    tick(); drive(p6, 1'b0, 1'b1);    // cycle 6
    n_asrt++; if (mult_start !== 1'b0) fail("b_c6_start");
    n_asrt++; if (busy !== 1'b0) fail("b_c6_busy");
    tick(); drive(p6, 1'b0, 1'b1);    // cycle 7
    n_asrt++; if (mult_start !== 1'b1) fail("b_c7_start");
    n_asrt++; if (mult_pkg_out !== p6) fail("b_c7_pkg");
    tick(); drive(p6, 1'b0, 1'b1);    // cycle 8
    n_asrt++; if (mult_start !== 1'b0) fail("b_c8_start");
    for (int i = 9; i <= 10; i++) begin
      tick(); drive(p6, 1'b0, 1'b1);
    end
    tick(); drive(p6, 1'b0, 1'b1);    // cycle 11
    n_asrt++; if (mult_done !== 1'b1) fail("b_c11_done");
    tick(); drive('0, 1'b0, 1'b1);    // cycle 12
    n_asrt++; if (busy !== 1'b0) fail("b_c12_busy");
    n_asrt++; if (mult_start !== 1'b0) fail("b_c12_start");
`ifdef MULT_PERF_CNT_EN
    exp_ops = 16'd4;
`endif
    n_asrt++; if (perf_ops !== exp_ops) fail("b_perf_ops");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
